// File: rtl/seg_scan_ctrl_pkg.sv
// Shared constants for the seven-segment display blocks: active-low segment
// patterns (bit6=CA .. bit0=CG) and the all-off cathode/anode values.
package seg_pkg;

  localparam logic [6:0] SEG_OFF = 7'b1111111;
  localparam logic [3:0] AN_OFF  = 4'b1111;

  // Index k holds the pattern for hex digit k.
  localparam logic [15:0][6:0] SEG_PAT = {
    7'b0111000,  // F
    7'b0110000,  // E
    7'b1000010,  // d
    7'b0110001,  // C
    7'b1100000,  // b
    7'b0001000,  // A
    7'b0000100,  // 9
    7'b0000000,  // 8
    7'b0001111,  // 7
    7'b0100000,  // 6
    7'b0100100,  // 5
    7'b1001100,  // 4
    7'b0000110,  // 3
    7'b0010010,  // 2
    7'b1001111,  // 1
    7'b0000001   // 0
  };

  typedef enum logic {
    PH_BLANK,
    PH_DRIVE
  } phase_e;

endpackage

// File: rtl/seg_scan_ctrl_if.sv
// Value-producer / display-pin bundle of the scan controller.
interface seg_scan_ctrl_if;

  logic [15:0] val_i;
  logic        upd_i;
  logic [3:0]  en_i;
  logic [3:0]  dp_i;
  logic        lz_blank_i;
  logic [6:0]  seg_n_o;
  logic        dp_n_o;
  logic [3:0]  an_n_o;
  logic [1:0]  digit_o;
  logic        frame_o;
  logic        pending_o;

  modport master (
    output val_i, upd_i, en_i, dp_i, lz_blank_i,
    input  seg_n_o, dp_n_o, an_n_o, digit_o, frame_o, pending_o
  );

  modport slave (
    input  val_i, upd_i, en_i, dp_i, lz_blank_i,
    output seg_n_o, dp_n_o, an_n_o, digit_o, frame_o, pending_o
  );

endinterface

// File: rtl/seg_scan_ctrl_hex7seg_dec.sv
// Combinational hex nibble to active-low seven-segment pattern decoder.
module hex7seg_dec
  import seg_pkg::*;
(
  input  logic [3:0] nib_i,
  output logic [6:0] seg_n_o
);

  assign seg_n_o = SEG_PAT[nib_i];

endmodule

// File: rtl/seg_scan_ctrl.sv
// Four-digit time-multiplexed seven-segment scan controller with per-slot
// blanking, frame-aligned value updates and leading-zero suppression.
module seg_scan_ctrl
  import seg_pkg::*;
#(
  parameter int unsigned DWELL_CYCLES = 50000,
  parameter int unsigned BLANK_CYCLES = 500
) (
  input logic            clk,
  input logic            reset,
  seg_scan_ctrl_if.slave bus
);

  localparam int unsigned    CW        = (DWELL_CYCLES > 1) ? $clog2(DWELL_CYCLES) : 1;
  localparam logic [CW-1:0]  CNT_LAST  = CW'(DWELL_CYCLES - 1);
  localparam logic [CW-1:0]  CNT_BLANK = CW'(BLANK_CYCLES);

  logic [CW-1:0] cnt_q, cnt_d;
  logic [1:0]    digit_q, digit_d;
  logic [15:0]   shown_q, shown_d;
  logic [15:0]   pval_q, pval_d;
  logic          pend_q, pend_d;
  logic [3:0]    an_q, an_d;
  logic [6:0]    seg_q, seg_d;
  logic          dpn_q, dpn_d;
  logic          frame_q, frame_d;

  logic          last_cnt;
  logic          wrap;
  phase_e        phase;
  logic [3:0]    nibble;
  logic [6:0]    dec_seg;
  logic [3:0]    supp;

  hex7seg_dec u_dec (
    .nib_i   (nibble),
    .seg_n_o (dec_seg)
  );

  always_comb begin
    last_cnt = (cnt_q == CNT_LAST);
    wrap     = last_cnt && (digit_q == 2'd3);
    phase    = (cnt_q < CNT_BLANK) ? PH_BLANK : PH_DRIVE;
    nibble   = shown_q[{digit_q, 2'b00} +: 4];

    // A digit is suppressed only while it and every higher nibble are zero.
    supp[3] = bus.lz_blank_i && (shown_q[15:12] == 4'h0);
    supp[2] = supp[3] && (shown_q[11:8] == 4'h0);
    supp[1] = supp[2] && (shown_q[7:4] == 4'h0);
    supp[0] = 1'b0;
  end

  always_comb begin
    cnt_d   = last_cnt ? '0 : cnt_q + 1'b1;
    digit_d = last_cnt ? digit_q + 2'd1 : digit_q;
    frame_d = wrap;
    pval_d  = bus.upd_i ? bus.val_i : pval_q;
    pend_d  = pend_q;
    shown_d = shown_q;

    // An update coincident with the wrap bypasses the pending register.
    if (wrap) begin
      pend_d = 1'b0;
      if (bus.upd_i) begin
        shown_d = bus.val_i;
      end else if (pend_q) begin
        shown_d = pval_q;
      end
    end else if (bus.upd_i) begin
      pend_d = 1'b1;
    end

    an_d  = AN_OFF;
    seg_d = SEG_OFF;
    dpn_d = 1'b1;
    if (phase == PH_DRIVE && bus.en_i[digit_q] && !supp[digit_q]) begin
      an_d[digit_q] = 1'b0;
      seg_d         = dec_seg;
      dpn_d         = ~bus.dp_i[digit_q];
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt_q   <= '0;
      digit_q <= '0;
      shown_q <= '0;
      pval_q  <= '0;
      pend_q  <= 1'b0;
      an_q    <= AN_OFF;
      seg_q   <= SEG_OFF;
      dpn_q   <= 1'b1;
      frame_q <= 1'b0;
    end else begin
      cnt_q   <= cnt_d;
      digit_q <= digit_d;
      shown_q <= shown_d;
      pval_q  <= pval_d;
      pend_q  <= pend_d;
      an_q    <= an_d;
      seg_q   <= seg_d;
      dpn_q   <= dpn_d;
      frame_q <= frame_d;
    end
  end

  assign bus.an_n_o    = an_q;
  assign bus.seg_n_o   = seg_q;
  assign bus.dp_n_o    = dpn_q;
  assign bus.digit_o   = digit_q;
  assign bus.frame_o   = frame_q;
  assign bus.pending_o = pend_q;

endmodule
